// File: rtl/mpu_command_loader_pkg.sv
// Shared definitions for the MPU command loader.
// Holds the operand widths, opcode constants, loader state encoding and
// the helper that maps a (row, col) element position to its slot in a
// packed 5x5 matrix of signed bytes.
package mpu_command_loader_pkg;

    localparam int MATRIX_5X5_W = 200;
    localparam int INTEGER_8_W  = 8;
    localparam int DIM          = 5;

    typedef logic [MATRIX_5X5_W-1:0]       matrix_5x5_t;
    typedef logic signed [INTEGER_8_W-1:0] integer_8_t;

    localparam logic [2:0] OP_ADD      = 3'd0;
    localparam logic [2:0] OP_SUB      = 3'd1;
    localparam logic [2:0] OP_SCALAR   = 3'd2;
    localparam logic [2:0] OP_OPPOSITE = 3'd3;
    localparam logic [2:0] OP_TRANSP   = 3'd4;
    localparam logic [2:0] OP_DET      = 3'd5;
    localparam logic [2:0] OP_MATMUL   = 3'd6;
    localparam logic [2:0] OP_INVALID  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FACTOR,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND
    } state_e;

    // Element k = row*5 + col; the storage row pitch is always 5.
    function automatic logic [4:0] elem_idx(input logic [2:0] row, input logic [2:0] col);
        return 5'(row) * 5'd5 + 5'(col);
    endfunction

endpackage

// File: rtl/mpu_result_serializer.sv
// Result buffer and byte serializer.
// Captures the MPU result (or determinant) when load_i pulses, then streams
// it out row-major over a valid/ready handshake.
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   load_i               : capture result_i / det_i into the buffer, start sending
//   is_det_i             : current command emits a single determinant byte
//   size_i               : matrix dimension (2..5)
//   result_i, det_i      : MPU outputs
//   out_data, out_valid  : result byte stream
//   out_ready            : downstream ready
//   last_o               : final byte accepted this cycle
module mpu_result_serializer
    import mpu_command_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              is_det_i,
    input  logic [2:0]        size_i,
    input  logic [199:0]      result_i,
    input  logic signed [7:0] det_i,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              last_o
);

    matrix_5x5_t buf_q, buf_d;
    logic        active_q, active_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        fire;
    logic        last_elem;

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q    <= '0;
            active_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            buf_q    <= buf_d;
            active_q <= active_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

    always_comb begin
        buf_d     = buf_q;
        active_d  = active_q;
        row_d     = row_q;
        col_d     = col_q;
        fire      = active_q & out_ready;
        // A determinant lives in element 0, so the counters never move for it.
        last_elem = is_det_i || ((row_q == size_i - 3'd1) && (col_q == size_i - 3'd1));
        last_o    = fire & last_elem;

        if (load_i) begin
            buf_d    = is_det_i ? {192'b0, det_i} : result_i;
            active_d = 1'b1;
            row_d    = '0;
            col_d    = '0;
        end else if (fire) begin
            if (last_elem) begin
                active_d = 1'b0;
                row_d    = '0;
                col_d    = '0;
            end else if (col_q == size_i - 3'd1) begin
                col_d = '0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    assign out_valid = active_q;
    assign out_data  = buf_q[{elem_idx(row_q, col_q), 3'b000} +: 8];

endmodule

// File: rtl/mpu_command_loader.sv
// Command loader for the matrix processing unit.
// Parses a header byte (opcode + size), an optional scalar factor and one or
// two row-major operand matrices from an input byte stream, pulses issue to
// the MPU, captures its result and streams it back out.
// Ports:
//   clock, reset                 : system clock, synchronous active-high reset
//   in_data/in_valid/in_ready    : command and element byte stream
//   operation, size, factor      : operands to the MPU
//   matrix_a, matrix_b           : packed 5x5 signed-byte operands
//   result, determinant          : MPU outputs
//   out_data/out_valid/out_ready : result byte stream
//   issue                        : one-cycle operand-valid pulse
//   busy                         : loader not idle
//   error                        : sticky bad-header flag
module mpu_command_loader
    import mpu_command_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2:0]        operation,
    output logic [199:0]      matrix_a,
    output logic [199:0]      matrix_b,
    output logic [7:0]        size,
    output logic [7:0]        factor,
    input  logic [199:0]      result,
    input  logic signed [7:0] determinant,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              issue,
    output logic              busy,
    output logic              error
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  size_q, size_d;
    logic [7:0]  factor_q, factor_d;
    matrix_5x5_t mat_a_q, mat_a_d;
    matrix_5x5_t mat_b_q, mat_b_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        err_q, err_d;

    logic        in_fire;
    logic        last_elem;
    logic        load_res;
    logic        ser_last;
    logic [2:0]  hdr_op;
    logic [2:0]  hdr_size;
    logic [7:0]  wr_base;

    assign hdr_op   = in_data[2:0];
    assign hdr_size = in_data[5:3];
    assign wr_base  = {elem_idx(row_q, col_q), 3'b000};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            size_q   <= '0;
            factor_q <= '0;
            mat_a_q  <= '0;
            mat_b_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            size_q   <= size_d;
            factor_q <= factor_d;
            mat_a_q  <= mat_a_d;
            mat_b_q  <= mat_b_d;
            row_q    <= row_d;
            col_q    <= col_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        size_d    = size_q;
        factor_d  = factor_q;
        mat_a_d   = mat_a_q;
        mat_b_d   = mat_b_q;
        row_d     = row_q;
        col_d     = col_q;
        err_d     = err_q;
        in_ready  = (state_q == ST_IDLE) || (state_q == ST_FACTOR) ||
                    (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
        issue     = (state_q == ST_ISSUE);
        busy      = (state_q != ST_IDLE);
        load_res  = (state_q == ST_WAIT);
        in_fire   = in_valid & in_ready;
        last_elem = (row_q == size_q[2:0] - 3'd1) && (col_q == size_q[2:0] - 3'd1);

        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    // A bad header is dropped; error stays set until a good one arrives.
                    if (hdr_op == OP_INVALID || hdr_size < 3'd2 || hdr_size > 3'd5) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        op_d    = hdr_op;
                        size_d  = {5'b0, hdr_size};
                        mat_a_d = '0;
                        mat_b_d = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = (hdr_op == OP_SCALAR) ? ST_FACTOR : ST_LOAD_A;
                    end
                end
            end
            ST_FACTOR: begin
                if (in_fire) begin
                    factor_d = in_data;
                    state_d  = ST_LOAD_A;
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                if (in_fire) begin
                    if (state_q == ST_LOAD_A) mat_a_d[wr_base +: 8] = in_data;
                    else                      mat_b_d[wr_base +: 8] = in_data;
                    if (last_elem) begin
                        row_d = '0;
                        col_d = '0;
                        if (state_q == ST_LOAD_A &&
                            (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_MATMUL))
                            state_d = ST_LOAD_B;
                        else
                            state_d = ST_ISSUE;
                    end else if (col_q == size_q[2:0] - 3'd1) begin
                        col_d = '0;
                        row_d = row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_SEND;
            ST_SEND:  if (ser_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    mpu_result_serializer u_ser (
        .clock     (clock),
        .reset     (reset),
        .load_i    (load_res),
        .is_det_i  (op_q == OP_DET),
        .size_i    (size_q[2:0]),
        .result_i  (result),
        .det_i     (determinant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last_o    (ser_last)
    );

    assign operation = op_q;
    assign size      = size_q;
    assign factor    = factor_q;
    assign matrix_a  = mat_a_q;
    assign matrix_b  = mat_b_q;
    assign error     = err_q;

endmodule

// File: tb/tb_mpu_command_loader.sv
module tb_mpu_command_loader;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        operation;
    logic [199:0]      matrix_a;
    logic [199:0]      matrix_b;
    logic [7:0]        size;
    logic [7:0]        factor;
    logic [199:0]      result;
    logic signed [7:0] determinant;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              issue;
    logic              busy;
    logic              error;

    int checks   = 0;
    int failures = 0;

    mpu_command_loader dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operation   (operation),
        .matrix_a    (matrix_a),
        .matrix_b    (matrix_b),
        .size        (size),
        .factor      (factor),
        .result      (result),
        .determinant (determinant),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .issue       (issue),
        .busy        (busy),
        .error       (error)
    );

    always #5 clock = ~clock;

    // Behavioural MPU: elementwise ops over the full 5x5 grid (unused cells are zero).
    function automatic logic [199:0] mpu_model(input logic [2:0] op, input logic [199:0] a,
                                               input logic [199:0] b, input logic [7:0] f);
        logic [199:0]      r;
        logic signed [7:0] ea, eb, acc;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                ea = a[(i*5+j)*8 +: 8];
                eb = b[(i*5+j)*8 +: 8];
                case (op)
                    3'd0: r[(i*5+j)*8 +: 8] = ea + eb;
                    3'd1: r[(i*5+j)*8 +: 8] = ea - eb;
                    3'd2: r[(i*5+j)*8 +: 8] = ea * $signed(f);
                    3'd3: r[(i*5+j)*8 +: 8] = -ea;
                    3'd4: r[(i*5+j)*8 +: 8] = a[(j*5+i)*8 +: 8];
                    3'd6: begin
                        acc = 8'sd0;
                        for (int k = 0; k < 5; k++)
                            acc = acc + $signed(a[(i*5+k)*8 +: 8]) * $signed(b[(k*5+j)*8 +: 8]);
                        r[(i*5+j)*8 +: 8] = acc;
                    end
                    default: r[(i*5+j)*8 +: 8] = 8'h00;
                endcase
            end
        end
        return r;
    endfunction

    assign result      = mpu_model(operation, matrix_a, matrix_b, factor);
    assign determinant = 8'sh07;

    // Monitor on the falling edge: issue count, operands seen at issue, latency.
    int           cyc = 0, issue_cnt = 0, issue_cyc = 0, ov_cyc = 0;
    logic         ov_prev = 1'b0;
    logic [7:0]   fac_at_issue;
    logic [199:0] a_at_issue;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (issue) begin
            issue_cnt    = issue_cnt + 1;
            issue_cyc    = cyc;
            fac_at_issue = factor;
            a_at_issue   = matrix_a;
        end
        if (out_valid && !ov_prev) ov_cyc = cyc;
        ov_prev = out_valid;
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        if (t >= 50) check("send_timeout", 1'b0, 1'b1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_all();
        foreach (stim_q[i]) send_byte(stim_q[i]);
        stim_q.delete();
    endtask

    // Receive exp_q.size() bytes; at index stall_at hold out_ready low for 5 cycles.
    task automatic recv_all(input int stall_at);
        int         t;
        logic [7:0] held;
        foreach (exp_q[i]) begin
            out_ready = (i != stall_at);
            t = 0;
            while (!out_valid && t < 50) begin
                @(posedge clock); #1;
                t++;
            end
            check("recv_valid", out_valid, 1'b1);
            if (i == stall_at) begin
                held = out_data;
                repeat (5) begin
                    @(posedge clock); #1;
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data", out_data, held);
                end
                out_ready = 1'b1;
            end
            check($sformatf("out_byte%0d", i), out_data, exp_q[i]);
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
        exp_q.delete();
        check("post_valid", out_valid, 1'b0);
        check("post_busy", busy, 1'b0);
    endtask

    int           n0;
    logic [199:0] exp_a;

    initial begin
        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_issue", issue, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_op_size_fac", {operation, size, factor}, 19'h0);
        check("rst_mats", {matrix_a, matrix_b}, 400'h0);

        // Add, size 2
        n0 = issue_cnt;
        stim_q = '{8'h10, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40};
        send_all();
        exp_q = '{8'd11, 8'd22, 8'd33, 8'd44};
        recv_all(-1);
        check("add_issue_cnt", issue_cnt - n0, 1);
        check("add_latency", ov_cyc - issue_cyc, 2);

        // Scalar, size 3, factor -2, with a 5-cycle out_ready stall
        n0 = issue_cnt;
        stim_q = '{8'h1A, 8'hFE, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_all();
        exp_q = '{8'hFE, 8'hFC, 8'hFA, 8'hF8, 8'hF6, 8'hF4, 8'hF2, 8'hF0, 8'hEE};
        recv_all(2);
        check("scl_issue_cnt", issue_cnt - n0, 1);
        check("scl_factor", fac_at_issue, 8'hFE);
        exp_a = '0;
        exp_a[7:0]   = 8'd1; exp_a[15:8]  = 8'd2; exp_a[23:16] = 8'd3;
        exp_a[47:40] = 8'd4; exp_a[55:48] = 8'd5; exp_a[63:56] = 8'd6;
        exp_a[87:80] = 8'd7; exp_a[95:88] = 8'd8; exp_a[103:96] = 8'd9;
        check("scl_matrix_a", a_at_issue, exp_a);
        check("scl_a_outside", {104'b0, a_at_issue[199:104]}, 200'h0);
        check("scl_latency", ov_cyc - issue_cyc, 2);

        // Determinant, size 5: one byte out
        n0 = issue_cnt;
        stim_q = '{8'h2D};
        for (int i = 1; i <= 25; i++) stim_q.push_back(8'(i));
        send_all();
        exp_q = '{8'h07};
        recv_all(-1);
        check("det_issue_cnt", issue_cnt - n0, 1);

        // Bad headers, then a good one clears error
        n0 = issue_cnt;
        send_byte(8'h07);
        check("err_op7", error, 1'b1);
        check("err_op7_ready", in_ready, 1'b1);
        check("err_op7_busy", busy, 1'b0);
        send_byte(8'h08);
        check("err_size1", error, 1'b1);
        check("err_size1_ready", in_ready, 1'b1);
        check("err_no_issue", issue_cnt - n0, 0);
        send_byte(8'h13);
        check("err_cleared", error, 1'b0);
        stim_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        send_all();
        exp_q = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
        recv_all(-1);

        // Sub, transpose and matrix-multiply, size 2
        stim_q = '{8'h11, 8'd5, 8'd0, 8'hFD, 8'd7, 8'd10, 8'd1, 8'd2, 8'd7};
        send_all();
        exp_q = '{8'hFB, 8'hFF, 8'hFB, 8'h00};
        recv_all(-1);
        stim_q = '{8'h14, 8'd1, 8'd2, 8'd3, 8'd4};
        send_all();
        exp_q = '{8'd1, 8'd3, 8'd2, 8'd4};
        recv_all(-1);
        stim_q = '{8'h16, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        send_all();
        exp_q = '{8'd19, 8'd22, 8'd43, 8'd50};
        recv_all(-1);

        // Reset after 3 of 4 A bytes
        n0 = issue_cnt;
        stim_q = '{8'h10, 8'd1, 8'd2, 8'd3};
        send_all();
        check("mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_size", size, 8'h00);
        check("mid_rst_mat_a", matrix_a, 200'h0);
        check("mid_rst_outs", {issue, out_valid, error}, 3'b000);
        repeat (3) @(posedge clock);
        #1 check("mid_no_issue", issue_cnt - n0, 0);
        stim_q = '{8'h10, 8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd1, 8'd1, 8'd1};
        send_all();
        exp_q = '{8'd6, 8'd7, 8'd8, 8'd9};
        recv_all(-1);
        check("mid_issue_cnt", issue_cnt - n0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
